// File: rtl/edit_pkg.sv
// Shared definitions for the cell-grid edit controller: grid geometry,
// controller state encoding and the cell address helper.
package edit_pkg;

  localparam int GRID_W     = 20;  // cells per row (640 / 32)
  localparam int GRID_H     = 15;  // cells per column (480 / 32)
  localparam int CELL_SHIFT = 5;   // log2 of the 32-pixel cell size

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EDIT  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Linear canvas address of cell (x, y) on a grid grid_w cells wide.
  function automatic int unsigned addr(input int unsigned x,
                                       input int unsigned y,
                                       input int unsigned grid_w);
    return y * grid_w + x;
  endfunction

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO holding pending canvas writes {addr, data}.
// Handshake: an entry moves in on a clock edge where i_push is high and the
// FIFO is not full, or is full but i_pop removes an entry on the same edge;
// otherwise the push is dropped. An entry moves out on an edge where i_pop is
// high and o_empty is low; o_dout always shows the oldest entry.
// i_flush discards every entry on the edge it is sampled.
module wr_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the same edge pops an entry.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers and occupancy count; reset and flush both empty the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/edit_ctrl.sv
// Edit-mode controller: owns the editing cursor and edit flag, turns button
// pulses into cursor moves and queued cell writes, and issues canvas writes
// only while the display is blanking. A clear walks every cell writing 0.
module edit_ctrl #(
  parameter int GRID_W     = edit_pkg::GRID_W,
  parameter int GRID_H     = edit_pkg::GRID_H,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_edit,
  input  logic              btn_draw,
  input  logic              btn_erase,
  input  logic              btn_clear,
  output logic              editing,
  output logic [4:0]        writing_x,
  output logic [4:0]        writing_y,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_wdata,
  output logic              busy,
  output edit_pkg::state_t  dbg_state
);

  import edit_pkg::*;

  localparam int CELLS = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [4:0]        X_MAX     = 5'(GRID_W - 1);
  localparam logic [4:0]        Y_MAX     = 5'(GRID_H - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            r_ret_state;
  state_t            w_ret_nxt;
  logic              r_editing;
  logic              w_editing_nxt;
  logic [4:0]        r_x;
  logic [4:0]        r_y;
  logic [4:0]        w_x_nxt;
  logic [4:0]        w_y_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_wdata;
  logic              r_busy;

  logic              w_clear_go;
  logic              w_clr_issue;
  logic              w_clr_last;
  logic              w_wr_req;
  logic              w_fifo_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [ADDR_W:0]   w_fifo_din;
  logic [ADDR_W:0]   w_fifo_dout;

  // A clear request is accepted from any state except CLEAR itself.
  assign w_clear_go  = btn_clear & (r_state != CLEAR);
  // CLEAR only exists while addresses remain, so every blank cycle writes one.
  assign w_clr_issue = (r_state == CLEAR) & ~valid;
  assign w_clr_last  = w_clr_issue & (r_clr_cnt == LAST_ADDR);
  // No FIFO write on the clear-entry edge: those entries are being discarded.
  assign w_fifo_pop  = (r_state != CLEAR) & ~w_clear_go & ~valid & ~w_fifo_empty;
  assign w_wr_req    = (r_state == EDIT) & ~btn_clear & (btn_draw | btn_erase);
  // Address uses the cursor before any same-cycle move; draw beats erase.
  assign w_cur_addr  = ADDR_W'(addr(32'(r_x), 32'(r_y), 32'(GRID_W)));
  assign w_fifo_din  = {w_cur_addr, btn_draw};

  wr_fifo #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (w_clear_go),
    .i_push  (w_wr_req),
    .i_din   (w_fifo_din),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state logic: edit toggling, clear entry with saved return state.
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret_state;
    w_editing_nxt = r_editing;
    unique case (r_state)
      IDLE: begin
        if (btn_clear) begin
          w_state_nxt = CLEAR;
          w_ret_nxt   = IDLE;
        end else if (btn_edit) begin
          w_state_nxt   = EDIT;
          w_editing_nxt = 1'b1;
        end
      end
      EDIT: begin
        if (btn_clear) begin
          w_state_nxt = CLEAR;
          w_ret_nxt   = EDIT;
        end else if (btn_edit) begin
          w_state_nxt   = IDLE;
          w_editing_nxt = 1'b0;
        end
      end
      CLEAR: begin
        if (w_clr_last) w_state_nxt = r_ret_state;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Cursor moves with wrap-around; opposing pulses cancel on that axis.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_state == EDIT && !btn_clear) begin
      if (btn_right && !btn_left)      w_x_nxt = (r_x == X_MAX) ? 5'd0 : r_x + 5'd1;
      else if (btn_left && !btn_right) w_x_nxt = (r_x == 5'd0) ? X_MAX : r_x - 5'd1;
      if (btn_down && !btn_up)         w_y_nxt = (r_y == Y_MAX) ? 5'd0 : r_y + 5'd1;
      else if (btn_up && !btn_down)    w_y_nxt = (r_y == 5'd0) ? Y_MAX : r_y - 5'd1;
    end
  end

  // State, return state, edit flag and cursor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ret_state <= IDLE;
      r_editing   <= 1'b0;
      r_x         <= 5'd0;
      r_y         <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_editing   <= w_editing_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
    end
  end

  // Clear address walker, restarted on every clear entry.
  always_ff @(posedge clk) begin
    if (rst || w_clear_go) begin
      r_clr_cnt <= '0;
    end else if (w_clr_issue) begin
      r_clr_cnt <= r_clr_cnt + ADDR_ONE;
    end
  end

  // Canvas write port: one registered write per blank edge with a source.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 1'b0;
    end else if (w_clr_issue) begin
      r_we    <= 1'b1;
      r_waddr <= r_clr_cnt;
      r_wdata <= 1'b0;
    end else if (w_fifo_pop) begin
      r_we    <= 1'b1;
      r_waddr <= w_fifo_dout[ADDR_W:1];
      r_wdata <= w_fifo_dout[0];
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Busy flag, one cycle behind the full / clearing condition.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= 1'b0;
    else     r_busy <= w_fifo_full | (r_state == CLEAR);
  end

  assign editing   = r_editing;
  assign writing_x = r_x;
  assign writing_y = r_y;
  assign mem_we    = r_we;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule
